// File: rtl/game_pkg.sv
// Shared game definitions: ghost movement modes and the scatter/chase phase
// duration table. Used by ghost_mode_scheduler and game_ghost.
package game_pkg;

  // Encoding doubles as the scheduler's mode output.
  typedef enum logic [1:0] {
    ModeScatter = 2'b00,
    ModeChase   = 2'b01,
    ModeFright  = 2'b10,
    ModeIdle    = 2'b11
  } mode_e;

  localparam logic [2:0]  LastPhase     = 3'd7;
  localparam logic [10:0] PhaseTimerMax = 11'd2047;

  // Frames per phase; even phases scatter, odd phases chase. Entry 7 is unlimited
  // and its value is never consulted.
  localparam logic [10:0] PhaseDur [8] = '{
    11'd420, 11'd1200, 11'd420, 11'd1200, 11'd300, 11'd1200, 11'd300, 11'd0
  };

endpackage

// File: rtl/fright_timer.sv
// Frightened-mode countdown with end-of-fright flash generation.
// Ports:
//   clk_i, rst_i  frame clock, async active-high reset
//   clear_i       synchronous clear of count and flash (players reset)
//   load_i        reload count to FRIGHT_FRAMES-1 (pellet eaten)
//   tick_i        frame advance enable (not paused)
//   run_i         scheduler is currently in FRIGHT
//   expire_o      count is at 0 and advancing: fright ends on this edge
//   flash_o       registered flash level for white ghosts
module fright_timer #(
  parameter int unsigned FRIGHT_FRAMES = 360,
  parameter int unsigned FLASH_FRAMES  = 120,
  parameter int unsigned FLASH_HALF    = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic load_i,
  input  logic tick_i,
  input  logic run_i,
  output logic expire_o,
  output logic flash_o
);

  localparam logic [8:0] LoadVal = 9'(FRIGHT_FRAMES - 1);

  logic [8:0] count_q, count_d;
  logic       flash_q, flash_d;

  // Flash level for a given count: high for the first FLASH_HALF frames of the
  // window (starting at FLASH_FRAMES-1), then alternating every FLASH_HALF.
  function automatic logic flash_at(logic [8:0] t);
    int unsigned ti;
    ti = 32'(t);
    if (ti >= FLASH_FRAMES) return 1'b0;
    return 1'(((FLASH_FRAMES - 1 - ti) / FLASH_HALF) % 2 == 0);
  endfunction

  assign expire_o = run_i & tick_i & ~load_i & (count_q == 9'd0);
  assign flash_o  = flash_q;

  always_comb begin
    count_d = count_q;
    flash_d = flash_q;
    if (clear_i) begin
      count_d = 9'd0;
      flash_d = 1'b0;
    end else if (load_i) begin
      count_d = LoadVal;
      flash_d = flash_at(LoadVal);
    end else if (run_i && tick_i) begin
      if (count_q == 9'd0) begin
        flash_d = 1'b0;
      end else begin
        count_d = count_q - 9'd1;
        flash_d = flash_at(count_q - 9'd1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 9'd0;
      flash_q <= 1'b0;
    end else begin
      count_q <= count_d;
      flash_q <= flash_d;
    end
  end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Ghost mode scheduler: sequences scatter/chase phases, handles power-pellet
// frightened mode and issues ghost reversal pulses.
// Ports:
//   clk_i, rst_i           60 Hz frame clock, async active-high reset
//   start_i                leave IDLE into phase 0 scatter
//   players_reset_i        return to IDLE on next edge (highest priority)
//   pause_i                freeze timers (pellets still act)
//   power_pellet_eaten_i   one-frame pulse
//   mode_o                 00 scatter, 01 chase, 10 fright, 11 idle
//   phase_o                scatter/chase phase index
//   reverse_o              one-frame reverse command
//   fright_flash_o         draw ghosts white
module ghost_mode_scheduler
  import game_pkg::*;
#(
  parameter int unsigned FRIGHT_FRAMES = 360,
  parameter int unsigned FLASH_FRAMES  = 120,
  parameter int unsigned FLASH_HALF    = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       players_reset_i,
  input  logic       pause_i,
  input  logic       power_pellet_eaten_i,
  output logic [1:0] mode_o,
  output logic [2:0] phase_o,
  output logic       reverse_o,
  output logic       fright_flash_o
);

  mode_e       state_q, saved_q;
  logic [2:0]  phase_q;
  logic [10:0] ptimer_q;
  logic        reverse_q;

  logic  in_phase, in_fright, phase_expire, pellet_take, fright_expire;
  mode_e toggled_mode, phase_mode;

  assign in_phase     = (state_q == ModeScatter) || (state_q == ModeChase);
  assign in_fright    = (state_q == ModeFright);
  assign phase_expire = in_phase && !pause_i && (phase_q != LastPhase) &&
                        (ptimer_q == PhaseDur[phase_q] - 11'd1);
  assign toggled_mode = (state_q == ModeScatter) ? ModeChase : ModeScatter;
  // Mode after this edge's phase bookkeeping; a same-edge pellet saves this one.
  assign phase_mode   = phase_expire ? toggled_mode : state_q;
  assign pellet_take  = power_pellet_eaten_i && (in_phase || in_fright);

  fright_timer #(
    .FRIGHT_FRAMES (FRIGHT_FRAMES),
    .FLASH_FRAMES  (FLASH_FRAMES),
    .FLASH_HALF    (FLASH_HALF)
  ) u_fright_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (players_reset_i),
    .load_i   (pellet_take && !players_reset_i),
    .tick_i   (!pause_i),
    .run_i    (in_fright),
    .expire_o (fright_expire),
    .flash_o  (fright_flash_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ModeIdle;
      saved_q   <= ModeScatter;
      phase_q   <= 3'd0;
      ptimer_q  <= 11'd0;
      reverse_q <= 1'b0;
    end else if (players_reset_i) begin
      state_q   <= ModeIdle;
      saved_q   <= ModeScatter;
      phase_q   <= 3'd0;
      ptimer_q  <= 11'd0;
      reverse_q <= 1'b0;
    end else begin
      reverse_q <= 1'b0;
      case (state_q)
        ModeIdle: begin
          if (start_i) begin
            state_q  <= ModeScatter;
            phase_q  <= 3'd0;
            ptimer_q <= 11'd0;
          end
        end
        ModeScatter, ModeChase: begin
          if (phase_expire) begin
            phase_q   <= phase_q + 3'd1;
            ptimer_q  <= 11'd0;
            reverse_q <= 1'b1;
          end else if (!pause_i && ptimer_q != PhaseTimerMax) begin
            ptimer_q <= ptimer_q + 11'd1;
          end
          if (power_pellet_eaten_i) begin
            state_q   <= ModeFright;
            saved_q   <= phase_mode;
            reverse_q <= 1'b1;
          end else begin
            state_q <= phase_mode;
          end
        end
        ModeFright: begin
          if (power_pellet_eaten_i) begin
            reverse_q <= 1'b1;
          end else if (fright_expire) begin
            state_q <= saved_q;
          end
        end
        default: state_q <= ModeIdle;
      endcase
    end
  end

  assign mode_o    = state_q;
  assign phase_o   = phase_q;
  assign reverse_o = reverse_q;

endmodule
